// File: rtl/cla_lock_pkg.sv
// Shared types and constants for the locked-adder decoder: FSM state encoding,
// default operand width and the counter-width helper.
package cla_lock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CLA_W = 4;

    // Bits needed to hold any value in 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_lock_decoder_borrow_cell.sv
// One-bit full subtractor x - y - bin, reused serially by the decoder.
module borrow_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/cla_lock_decoder.sv
// Bit-serial unlock/decode of a keyed adder result: a = enca ^ k, b = s - enca - c.
// Optional range flag built only when CLA_LOCK_DECODER_RANGE_CHECK_EN is defined.
module cla_lock_decoder
    import cla_lock_pkg::*;
#(
    parameter int WIDTH = CLA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] enca,
    input  logic [WIDTH-1:0] k,
    input  logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_dec,
    output logic [WIDTH-1:0] b_dec,
    output logic             err
);

    localparam int             CNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH:0]   s_reg, e_reg;
    logic [WIDTH-1:0] d_reg;
    logic             bor_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             d_bit, bor_next;
    logic             last_bit;

    assign last_bit = (cnt_reg == CNT_LAST);

    // Operands shift right so the current bit is always at position 0.
    borrow_cell u_cell (
        .x    (s_reg[0]),
        .y    (e_reg[0]),
        .bin  (bor_reg),
        .d    (d_bit),
        .bout (bor_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SUB;
            end
            SUB:     if (last_bit) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg     <= '0;
            e_reg     <= '0;
            d_reg     <= '0;
            bor_reg   <= 1'b0;
            cnt_reg   <= '0;
            a_dec     <= '0;
            b_dec     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        s_reg   <= s;
                        e_reg   <= {1'b0, enca};
                        bor_reg <= c;
                        cnt_reg <= '0;
                        a_dec   <= enca ^ k;
                    end
                end
                SUB: begin
                    s_reg   <= {1'b0, s_reg[WIDTH:1]};
                    e_reg   <= {1'b0, e_reg[WIDTH:1]};
                    bor_reg <= bor_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // The top difference bit only feeds the range flag, so it is not shifted in.
                    if (!last_bit) begin
                        d_reg <= {d_bit, d_reg[WIDTH-1:1]};
                    end else begin
                        b_dec     <= d_reg;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef CLA_LOCK_DECODER_RANGE_CHECK_EN
    logic err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (state_reg == SUB && last_bit) begin
            err_reg <= bor_next | d_bit;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cla_lock_decoder.sv
// Directed bench for cla_lock_decoder: vector table plus backpressure and reset-abort sequences.
module tb_cla_lock_decoder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   s;
    logic [W-1:0] enca;
    logic [W-1:0] k;
    logic         c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a_dec;
    logic [W-1:0] b_dec;
    logic         err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_lock_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .enca      (enca),
        .k         (k),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_dec     (a_dec),
        .b_dec     (b_dec),
        .err       (err)
    );

    typedef struct {
        logic [W:0]   s;
        logic [W-1:0] enca;
        logic [W-1:0] k;
        logic         c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         err_rc;
    } vec_t;

    vec_t vecs[6];

`ifdef CLA_LOCK_DECODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one request, wait for out_valid; returns clocks from accept edge to out_valid.
    task automatic issue(input logic [W:0] vs, input logic [W-1:0] ve, input logic [W-1:0] vk,
                         input logic vc, output int lat);
        @(negedge clk);
        chk("in_ready_before_req", in_ready, 1);
        s = vs; enca = ve; k = vk; c = vc; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s = '1; enca = '1; k = '1; c = 1'b1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            failures++;
            checks++;
            $display("FAIL out_valid_timeout: got none expected within 20 clocks");
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        chk({tag, "_latency"}, lat, W + 1);
        chk({tag, "_a_dec"}, a_dec, v.a);
        chk({tag, "_b_dec"}, b_dec, v.b);
        chk({tag, "_err"}, err, v.err_rc & RC);
        chk({tag, "_in_ready_busy"}, in_ready, 0);
    endtask

    initial begin
        int lat;
        vecs[0] = '{s: 5'd29, enca: 4'b1111, k: 4'b1010, c: 1'b0, a: 4'd5,  b: 4'd14, err_rc: 1'b0};
        vecs[1] = '{s: 5'd20, enca: 4'd7,    k: 4'd0,    c: 1'b1, a: 4'd7,  b: 4'd12, err_rc: 1'b0};
        vecs[2] = '{s: 5'd0,  enca: 4'd1,    k: 4'd0,    c: 1'b0, a: 4'd1,  b: 4'd15, err_rc: 1'b1};
        vecs[3] = '{s: 5'd31, enca: 4'd0,    k: 4'd3,    c: 1'b0, a: 4'd3,  b: 4'd15, err_rc: 1'b1};
        vecs[4] = '{s: 5'd16, enca: 4'd9,    k: 4'd9,    c: 1'b1, a: 4'd0,  b: 4'd6,  err_rc: 1'b0};
        vecs[5] = '{s: 5'd15, enca: 4'd15,   k: 4'd5,    c: 1'b1, a: 4'd10, b: 4'd15, err_rc: 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        s = '0; enca = '0; k = '0; c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_a_dec", a_dec, 0);
        chk("rst_b_dec", b_dec, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].s, vecs[i].enca, vecs[i].k, vecs[i].c, lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid_clear", i), out_valid, 0);
            chk($sformatf("vec%0d_in_ready_after", i), in_ready, 1);
            $display("vec%0d s=%0d enca=%0d k=%0d c=%0d -> a=%0d b=%0d err=%0d lat=%0d",
                     i, vecs[i].s, vecs[i].enca, vecs[i].k, vecs[i].c, a_dec, b_dec, err, lat);
        end

        // Backpressure: hold out_ready low for 10 clocks while offering a new request.
        out_ready = 1'b0;
        issue(vecs[0].s, vecs[0].enca, vecs[0].k, vecs[0].c, lat);
        check_result("bp", vecs[0], lat);
        s = vecs[1].s; enca = vecs[1].enca; k = vecs[1].k; c = vecs[1].c; in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {out_valid, in_ready, a_dec, b_dec, err},
                {1'b1, 1'b0, vecs[0].a, vecs[0].b, 1'b0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        $display("bp stall 10 clocks -> a=%0d b=%0d released", a_dec, b_dec);

        // Reset two clocks into SUB aborts the request immediately.
        @(negedge clk);
        s = vecs[1].s; enca = vecs[1].enca; k = vecs[1].k; c = vecs[1].c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort_a_dec_pre", a_dec, vecs[1].a);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_a_dec", a_dec, 0);
        chk("abort_b_dec", b_dec, 0);
        chk("abort_err", err, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        issue(vecs[0].s, vecs[0].enca, vecs[0].k, vecs[0].c, lat);
        check_result("post_abort", vecs[0], lat);
        @(posedge clk);
        #1;
        chk("post_abort_in_ready", in_ready, 1);
        $display("abort then vec0 -> a=%0d b=%0d lat=%0d", a_dec, b_dec, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
